// File: rtl/up_count_pkg.sv
// Shared definitions for the up_count block: FSM state encoding and default widths.
package up_count_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 4;
    localparam int WRAPW_DEF = 8;

endpackage

// File: rtl/up_count_if.sv
// Control/status bundle of up_count; the counter is the slave, its driver the master.
interface up_count_if
    import up_count_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int WRAPW = WRAPW_DEF
);

    logic [WIDTH-1:0] N;
    logic             start;
    logic             stop;
    logic             en;
    logic             oneshot;
    logic [WIDTH-1:0] a;
    logic             tc;
    logic             busy;
    logic             done;
    logic [WRAPW-1:0] wraps;

    modport master (
        output N, start, stop, en, oneshot,
        input  a, tc, busy, done, wraps
    );

    modport slave (
        input  N, start, stop, en, oneshot,
        output a, tc, busy, done, wraps
    );

endinterface

// File: rtl/up_count_core.sv
// Count datapath: the count value, its captured limit and the wrap compare.
module up_count_core
    import up_count_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] n,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] a,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] limit;

    // A restart and a continuous-mode wrap are the same datapath action:
    // clear the count and capture a fresh limit from n.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a     <= '0;
            limit <= '0;
        end else if (load) begin
            a     <= '0;
            limit <= n;
        end else if (step) begin
            a <= a + ONE;
        end
    end

    assign at_limit = (a == limit);

endmodule

// File: rtl/up_count.sv
// Up counter to a sampled limit with one-shot/continuous modes, wrap pulse and pass counter.
module up_count
    import up_count_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int WRAPW = WRAPW_DEF
) (
    input  logic       clk,
    input  logic       rst,
    up_count_if.slave  bus
);

    localparam logic [WRAPW-1:0] WRAP_ONE = {{(WRAPW-1){1'b0}}, 1'b1};

    state_t           state;
    logic             mode_os;
    logic             tc_q;
    logic             busy_q;
    logic             done_q;
    logic [WRAPW-1:0] wraps_q;

    logic [WIDTH-1:0] a_q;
    logic             at_limit;
    logic             load;
    logic             step;
    logic             wrap_hit;

    // stop dominates everything; start dominates the count step in RUN.
    always_comb begin
        load     = 1'b0;
        step     = 1'b0;
        wrap_hit = 1'b0;
        if (!bus.stop) begin
            case (state)
                IDLE, DONE: load = bus.start;
                RUN: begin
                    if (bus.start) begin
                        load = 1'b1;
                    end else if (bus.en) begin
                        if (at_limit) begin
                            wrap_hit = 1'b1;
                            load     = !mode_os;
                        end else begin
                            step = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    up_count_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .n        (bus.N),
        .load     (load),
        .step     (step),
        .a        (a_q),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mode_os <= 1'b0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wraps_q <= '0;
        end else begin
            tc_q <= wrap_hit;
            case (state)
                IDLE, DONE: begin
                    if (bus.stop) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                    end else if (bus.start) begin
                        state   <= RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        mode_os <= bus.oneshot;
                        wraps_q <= '0;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (bus.start) begin
                        mode_os <= bus.oneshot;
                        wraps_q <= '0;
                    end else if (wrap_hit) begin
                        if (wraps_q != '1)
                            wraps_q <= wraps_q + WRAP_ONE;
                        if (mode_os) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a     = a_q;
    assign bus.tc    = tc_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.wraps = wraps_q;

endmodule
